// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_addr_gen
// Description : 3x3 convolution window read-address issuer. Raster-scans the
//               feature map and emits nine tap addresses per output pixel,
//               each with a padding flag.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_addr_gen #(
    parameter int ROW_BITS = 6,
    parameter int COL_BITS = 6,
    parameter int BASE_W   = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [BASE_W-1:0]            i_base,
    input  logic                         i_tapReady,
    output logic                         o_tapValid,
    output logic [BASE_W-1:0]            o_tapAddr,
    output logic [3:0]                   o_tapIdx,
    output logic                         o_tapPad,
    output logic [ROW_BITS+COL_BITS-1:0] o_localAddr,
    output logic                         o_lastTap,
    output logic                         o_lastWin,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int                c_loc_w    = ROW_BITS + COL_BITS;
    localparam logic [BASE_W-1:0] c_row_step = BASE_W'(1) << COL_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [BASE_W-1:0]   r_base_q,  w_base_d;
    logic [ROW_BITS-1:0] r_row_q,   w_row_d;
    logic [COL_BITS-1:0] r_col_q,   w_col_d;
    logic [3:0]          r_tap_q,   w_tap_d;

    logic                r_valid_q,    w_valid_d;
    logic [BASE_W-1:0]   r_addr_q,     w_addr_d;
    logic [3:0]          r_idx_q,      w_idx_d;
    logic                r_pad_q,      w_pad_d;
    logic [c_loc_w-1:0]  r_loc_q,      w_loc_d;
    logic                r_last_tap_q, w_last_tap_d;
    logic                r_last_win_q, w_last_win_d;
    logic                r_busy_q,     w_busy_d;
    logic                r_done_q,     w_done_d;

    logic                w_xfer;
    logic                w_run;
    logic                w_dr_neg, w_dr_pos, w_dc_neg, w_dc_pos;
    logic                w_row_max, w_col_max, w_row_zero, w_col_zero;
    logic                w_pad;
    logic [BASE_W-1:0]   w_center;
    logic [BASE_W-1:0]   w_row_off, w_col_off;

    assign w_xfer = r_valid_q & i_tapReady;

    // Scan counters and FSM next state
    always_comb begin
        w_state_d = r_state_q;
        w_base_d  = r_base_q;
        w_row_d   = r_row_q;
        w_col_d   = r_col_q;
        w_tap_d   = r_tap_q;
        case (r_state_q)
            S_IDLE: begin
                if (i_start) begin
                    w_state_d = S_RUN;
                    w_base_d  = i_base;
                    w_row_d   = '0;
                    w_col_d   = '0;
                    w_tap_d   = '0;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    if (r_tap_q == 4'd8) begin
                        w_tap_d = '0;
                        if ((&r_row_q) && (&r_col_q)) begin
                            w_state_d = S_DONE;
                        end else begin
                            w_col_d = r_col_q + COL_BITS'(1);
                            if (&r_col_q) begin
                                w_row_d = r_row_q + ROW_BITS'(1);
                            end
                        end
                    end else begin
                        w_tap_d = r_tap_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Tap fields are derived from the next counter values so the outputs are
    // registered yet line up with the tap the counters point at.
    always_comb begin
        w_run      = (w_state_d == S_RUN);
        w_dr_neg   = (w_tap_d < 4'd3);
        w_dr_pos   = (w_tap_d > 4'd5);
        w_dc_neg   = (w_tap_d == 4'd0) || (w_tap_d == 4'd3) || (w_tap_d == 4'd6);
        w_dc_pos   = (w_tap_d == 4'd2) || (w_tap_d == 4'd5) || (w_tap_d == 4'd8);
        w_row_max  = &w_row_d;
        w_col_max  = &w_col_d;
        w_row_zero = ~|w_row_d;
        w_col_zero = ~|w_col_d;
        w_pad      = (w_dr_neg & w_row_zero) | (w_dr_pos & w_row_max) |
                     (w_dc_neg & w_col_zero) | (w_dc_pos & w_col_max);

        w_center   = w_base_d + BASE_W'({w_row_d, w_col_d});
        w_row_off  = w_dr_neg ? ('0 - c_row_step) : (w_dr_pos ? c_row_step : '0);
        w_col_off  = w_dc_neg ? '1 : (w_dc_pos ? BASE_W'(1) : '0);

        w_valid_d    = w_run;
        w_addr_d     = '0;
        w_idx_d      = '0;
        w_pad_d      = 1'b0;
        w_loc_d      = '0;
        w_last_tap_d = 1'b0;
        w_last_win_d = 1'b0;
        if (w_run) begin
            w_addr_d     = w_pad ? w_center : (w_center + w_row_off + w_col_off);
            w_idx_d      = w_tap_d;
            w_pad_d      = w_pad;
            w_loc_d      = {w_row_d, w_col_d};
            w_last_tap_d = (w_tap_d == 4'd8);
            w_last_win_d = w_row_max & w_col_max;
        end
        w_busy_d = (w_state_d != S_IDLE);
        w_done_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= S_IDLE;
            r_base_q     <= '0;
            r_row_q      <= '0;
            r_col_q      <= '0;
            r_tap_q      <= '0;
            r_valid_q    <= 1'b0;
            r_addr_q     <= '0;
            r_idx_q      <= '0;
            r_pad_q      <= 1'b0;
            r_loc_q      <= '0;
            r_last_tap_q <= 1'b0;
            r_last_win_q <= 1'b0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_base_q     <= w_base_d;
            r_row_q      <= w_row_d;
            r_col_q      <= w_col_d;
            r_tap_q      <= w_tap_d;
            r_valid_q    <= w_valid_d;
            r_addr_q     <= w_addr_d;
            r_idx_q      <= w_idx_d;
            r_pad_q      <= w_pad_d;
            r_loc_q      <= w_loc_d;
            r_last_tap_q <= w_last_tap_d;
            r_last_win_q <= w_last_win_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
        end
    end

    assign o_tapValid  = r_valid_q;
    assign o_tapAddr   = r_addr_q;
    assign o_tapIdx    = r_idx_q;
    assign o_tapPad    = r_pad_q;
    assign o_localAddr = r_loc_q;
    assign o_lastTap   = r_last_tap_q;
    assign o_lastWin   = r_last_win_q;
    assign o_busy      = r_busy_q;
    assign o_done      = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_addr_gen
// Description : Bench for conv_window_addr_gen: two instances, one with ready
//               always high and one with random backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_addr_gen;

    localparam int NTAPS  = 9 * 4096;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic             clk;
    logic             rst;
    logic [1:0]       start, ready, valid, pad, ltap, lwin, busy, done;
    logic [1:0][15:0] base, addr;
    logic [1:0][3:0]  idx;
    logic [1:0][11:0] loc;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 0;

    int          phase[2], mn[2], off[2], first_off[2], last_off[2];
    int          done_off[2], ndone[2], nx[2];
    logic [15:0] mbase[2];
    bit          fin[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        conv_window_addr_gen u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_start     (start[g]),
            .i_base      (base[g]),
            .i_tapReady  (ready[g]),
            .o_tapValid  (valid[g]),
            .o_tapAddr   (addr[g]),
            .o_tapIdx    (idx[g]),
            .o_tapPad    (pad[g]),
            .o_localAddr (loc[g]),
            .o_lastTap   (ltap[g]),
            .o_lastWin   (lwin[g]),
            .o_busy      (busy[g]),
            .o_done      (done[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Expected {addr[16], pad, idx[4], loc[12], lastTap, lastWin} for transfer n.
    function automatic logic [34:0] model(input int n, input logic [15:0] b);
        int win, tap, row, col, dr, dc, a;
        bit p;
        logic [15:0] a16;
        win = n / 9;
        tap = n % 9;
        row = win / 64;
        col = win % 64;
        dr  = tap / 3 - 1;
        dc  = tap % 3 - 1;
        p   = (dr == -1 && row == 0) || (dr == 1 && row == 63) ||
              (dc == -1 && col == 0) || (dc == 1 && col == 63);
        a   = p ? (int'(b) + row * 64 + col) : (int'(b) + (row + dr) * 64 + (col + dc));
        a16 = a[15:0];
        return {a16, p, 4'(tap), 6'(row), 6'(col), tap == 8, win == 4095};
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge
    always @(negedge clk) begin
        logic [34:0] act;
        for (int g = 0; g < 2; g++) begin
            off[g]++;
            if (mon_en) begin
                act = {addr[g], pad[g], idx[g], loc[g], ltap[g], lwin[g]};
                case (phase[g])
                    P_RUN: begin
                        chk($sformatf("run_ctl i%0d", g), {valid[g], busy[g], done[g]}, 3'b110);
                        chk($sformatf("tap i%0d n%0d", g, mn[g]), act, model(mn[g], mbase[g]));
                    end
                    P_DONE: chk($sformatf("done_ctl i%0d", g), {valid[g], busy[g], done[g]}, 3'b011);
                    default: chk($sformatf("idle_ctl i%0d", g), {valid[g], busy[g], done[g]}, 3'b000);
                endcase
                if (valid[g] === 1'b1 && first_off[g] < 0) first_off[g] = off[g];
                if (valid[g] === 1'b1 && ready[g]) begin
                    last_off[g] = off[g];
                    nx[g]++;
                end
                if (done[g] === 1'b1) begin
                    done_off[g] = off[g];
                    ndone[g]++;
                    fin[g] = 1;
                end
            end
            if (rst) begin
                phase[g] = P_IDLE;
            end else begin
                case (phase[g])
                    P_IDLE: if (start[g]) begin
                        phase[g] = P_RUN;  mn[g] = 0;        mbase[g] = base[g];
                        off[g] = 0;        first_off[g] = -1; last_off[g] = -1;
                        done_off[g] = -1;  ndone[g] = 0;     nx[g] = 0;  fin[g] = 0;
                    end
                    P_RUN: if (ready[g]) begin
                        mn[g]++;
                        if (mn[g] == NTAPS) phase[g] = P_DONE;
                    end
                    default: phase[g] = P_IDLE;
                endcase
            end
        end
    end

    initial begin
        logic [34:0]      m;
        logic [15:0]      lit_addr [9];
        logic [8:0]       lit_pad;
        int               guard;
        for (int g = 0; g < 2; g++) begin
            phase[g] = P_IDLE; mn[g] = 0; ndone[g] = 0; nx[g] = 0; fin[g] = 0;
            off[g] = 0; first_off[g] = -1; last_off[g] = -1; done_off[g] = -1;
        end
        lit_addr = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000,
                     16'h1001, 16'h1000, 16'h1040, 16'h1041};
        lit_pad  = 9'b0_0100_1111;  // bit k = pad of tap k

        // Hand-computed pins for the model
        for (int k = 0; k < 9; k++) begin
            m = model(k, 16'h1000);
            chk($sformatf("model_w00 t%0d", k), {m[34:19], m[18]}, {lit_addr[k], lit_pad[k]});
        end
        m = model((5 * 64 + 10) * 9, 16'h1000);
        chk("model_w5_10 t0", {m[34:19], m[18]}, {16'h1109, 1'b0});
        m = model((5 * 64 + 10) * 9 + 8, 16'h1000);
        chk("model_w5_10 t8", {m[34:19], m[18]}, {16'h118B, 1'b0});  // (6<<6)+11
        for (int k = 0; k < 9; k++) begin
            m = model(4095 * 9 + k, 16'h1000);
            chk($sformatf("model_last t%0d", k), {m[18], m[0]},
                {(k == 2 || k == 5 || k == 6 || k == 7 || k == 8), 1'b1});
        end
        m = model(8, 16'hFFF0);
        chk("model_wrap t8", m[34:19], 16'h0031);

        rst = 1'b1; start = '0; ready = 2'b11; base = '0;
        @(posedge clk); #1;
        mon_en = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // First window on both instances, then reset mid-scan
        base[0] = 16'h1000; base[1] = 16'hFFF0; start = 2'b11;
        @(posedge clk); #1;
        start = '0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("dut_w00 t%0d", k), {valid[0], idx[0], addr[0], pad[0]},
                {1'b1, 4'(k), lit_addr[k], lit_pad[k]});
            if (k == 8) chk("dut_wrap t8", {pad[1], addr[1]}, {1'b0, 16'h0031});
            @(posedge clk); #1;
        end
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++)
            chk($sformatf("reset_zero i%0d", g),
                {valid[g], addr[g], idx[g], pad[g], loc[g], ltap[g], lwin[g], busy[g], done[g]}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_no_done i0", 64'(ndone[0]), 0);
        chk("reset_no_done i1", 64'(ndone[1]), 0);

        // Full scans: instance 0 ready always, instance 1 random ~50% ready
        base[0] = 16'h1000; base[1] = 16'($urandom); start = 2'b11;
        @(posedge clk); #1;
        start = '0;
        guard = 0;
        while (!(fin[0] && fin[1]) && guard < 80000) begin
            ready[0] = 1'b1;
            ready[1] = 1'($urandom % 2);
            for (int g = 0; g < 2; g++)
                start[g] = (phase[g] == P_RUN) && (mn[g] < 36000) &&
                           (guard == 100 || ($urandom % 3000) == 0);
            @(posedge clk); #1;
            guard++;
        end
        start = '0;
        chk("scan_budget", {fin[0], fin[1]}, 2'b11);
        repeat (3) @(posedge clk);
        #1;
        chk("first_valid i0", 64'(first_off[0]), 1);
        chk("last_xfer i0",   64'(last_off[0]), NTAPS);
        chk("done_cycle i0",  64'(done_off[0]), NTAPS + 1);
        chk("xfers i0",       64'(nx[0]), NTAPS);
        chk("done_count i0",  64'(ndone[0]), 1);
        chk("first_valid i1", 64'(first_off[1]), 1);
        chk("xfers i1",       64'(nx[1]), NTAPS);
        chk("done_count i1",  64'(ndone[1]), 1);
        chk("done_after i1",  64'(done_off[1]), 64'(last_off[1] + 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
